// File: rtl/cw_tx_sequencer.sv
// -----------------------------------------------------------------------------
// cw_tx_sequencer
// Purpose : CW transmit sequencer. Raises PTT, waits a lead delay, keys the
//           carrier while the keyer requests it, then holds PTT for a hang
//           time after the last element. A host PTT request can hold the
//           transmitter up without keying. tx_inhibit aborts everything.
// Ports   :
//   IF_clk      in   sole clock
//   IF_rst      in   asynchronous reset, active-high
//   tick_1ms    in   one-cycle strobe every 1 ms
//   cw_key_req  in   keyer element request
//   host_ptt    in   host/voice PTT request
//   tx_inhibit  in   abort/forbid transmit, highest priority
//   ptt_delay   in   ms between PTT rise and first key-down
//   hang_time   in   ms PTT is held after last key-up
//   ptt_out     out  T/R relay drive
//   cw_key_out  out  carrier key
//   txen_start  out  one-cycle pulse when ptt_out rises
//   txen_end    out  one-cycle pulse when ptt_out falls
//   state_o     out  current state encoding
//   elem_count  out  saturating count of key-down transitions
// -----------------------------------------------------------------------------
module cw_tx_sequencer #(
    parameter int unsigned CNT_W  = 10,
    parameter int unsigned ELEM_W = 16
) (
    input  logic              IF_clk,
    input  logic              IF_rst,
    input  logic              tick_1ms,
    input  logic              cw_key_req,
    input  logic              host_ptt,
    input  logic              tx_inhibit,
    input  logic [7:0]        ptt_delay,
    input  logic [9:0]        hang_time,
    output logic              ptt_out,
    output logic              cw_key_out,
    output logic              txen_start,
    output logic              txen_end,
    output logic [2:0]        state_o,
    output logic [ELEM_W-1:0] elem_count
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LEAD  = 3'd1;
    localparam logic [2:0] S_KEYED = 3'd2;
    localparam logic [2:0] S_HANG  = 3'd3;
    localparam logic [2:0] S_HOST  = 3'd4;

    // Comparison width covers the counter and the widest threshold input.
    localparam int unsigned CMP_W = ((CNT_W > 10) ? CNT_W : 10) + 1;

    logic [2:0]        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [ELEM_W-1:0] r_elem;
    logic              r_ptt;
    logic              r_key;
    logic              r_start;
    logic              r_end;

    logic [2:0]        w_next;
    logic [CNT_W-1:0]  w_cnt_inc;
    logic              w_lead_exp;
    logic              w_hang_exp;
    logic              w_next_ptt;

    // Saturating counter increment and timer expiry decisions.
    // ">=" lets a threshold lowered below the running count expire at the next tick.
    always_comb begin
        w_cnt_inc  = (&r_cnt) ? r_cnt : (r_cnt + CNT_W'(1));
        w_lead_exp = (ptt_delay == 8'd0) ||
                     (tick_1ms && (CMP_W'(w_cnt_inc) >= CMP_W'(ptt_delay)));
        w_hang_exp = (hang_time == 10'd0) ||
                     (tick_1ms && (CMP_W'(w_cnt_inc) >= CMP_W'(hang_time)));
    end

    // Next-state logic; priority is inhibit, key request, host PTT, timer.
    always_comb begin
        w_next = S_IDLE;
        if (tx_inhibit) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (cw_key_req)    w_next = S_LEAD;
                    else if (host_ptt) w_next = S_HOST;
                    else               w_next = S_IDLE;
                end
                S_LEAD: begin
                    if (!cw_key_req)     w_next = S_HANG;
                    else if (w_lead_exp) w_next = S_KEYED;
                    else                 w_next = S_LEAD;
                end
                S_KEYED: begin
                    if (!cw_key_req) w_next = S_HANG;
                    else             w_next = S_KEYED;
                end
                S_HANG: begin
                    if (cw_key_req)      w_next = S_KEYED;
                    else if (w_hang_exp) w_next = host_ptt ? S_HOST : S_IDLE;
                    else                 w_next = S_HANG;
                end
                S_HOST: begin
                    if (cw_key_req)     w_next = S_KEYED;
                    else if (!host_ptt) w_next = S_IDLE;
                    else                w_next = S_HOST;
                end
                default: w_next = S_IDLE;
            endcase
        end
    end

    // PTT is asserted in every valid non-idle state.
    always_comb begin
        w_next_ptt = 1'b0;
        case (w_next)
            S_LEAD, S_KEYED, S_HANG, S_HOST: w_next_ptt = 1'b1;
            default:                         w_next_ptt = 1'b0;
        endcase
    end

    // State register.
    always_ff @(posedge IF_clk or posedge IF_rst) begin
        if (IF_rst) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // ms counter: cleared on every state change, counts ticks in LEAD and HANG.
    always_ff @(posedge IF_clk or posedge IF_rst) begin
        if (IF_rst) begin
            r_cnt <= '0;
        end else if (w_next != r_state) begin
            r_cnt <= '0;
        end else if (tick_1ms && ((r_state == S_LEAD) || (r_state == S_HANG))) begin
            r_cnt <= w_cnt_inc;
        end
    end

    // Key-down counter, saturating at all-ones.
    always_ff @(posedge IF_clk or posedge IF_rst) begin
        if (IF_rst) begin
            r_elem <= '0;
        end else if ((w_next == S_KEYED) && (r_state != S_KEYED) && !(&r_elem)) begin
            r_elem <= r_elem + ELEM_W'(1);
        end
    end

    // Registered outputs, derived from the next state so they line up with state_o.
    always_ff @(posedge IF_clk or posedge IF_rst) begin
        if (IF_rst) begin
            r_ptt   <= 1'b0;
            r_key   <= 1'b0;
            r_start <= 1'b0;
            r_end   <= 1'b0;
        end else begin
            r_ptt   <= w_next_ptt;
            r_key   <= (w_next == S_KEYED);
            r_start <= w_next_ptt & ~r_ptt;
            r_end   <= ~w_next_ptt & r_ptt;
        end
    end

    assign ptt_out    = r_ptt;
    assign cw_key_out = r_key;
    assign txen_start = r_start;
    assign txen_end   = r_end;
    assign state_o    = r_state;
    assign elem_count = r_elem;

endmodule

// File: tb/tb_cw_tx_sequencer.sv
// -----------------------------------------------------------------------------
// tb_cw_tx_sequencer
// Purpose : self-checking bench for cw_tx_sequencer. A table of per-cycle
//           vectors covers the state machine; hand sequences cover the long
//           timing run, hang re-key, async reset and counter saturation.
// -----------------------------------------------------------------------------
module tb_cw_tx_sequencer;

    localparam int unsigned TB_ELEM_W = 3;

    logic                 IF_clk;
    logic                 IF_rst;
    logic                 tick_1ms;
    logic                 cw_key_req;
    logic                 host_ptt;
    logic                 tx_inhibit;
    logic [7:0]           ptt_delay;
    logic [9:0]           hang_time;
    logic                 ptt_out;
    logic                 cw_key_out;
    logic                 txen_start;
    logic                 txen_end;
    logic [2:0]           state_o;
    logic [TB_ELEM_W-1:0] elem_count;

    int checks = 0;
    int errors = 0;

    cw_tx_sequencer #(.CNT_W(10), .ELEM_W(TB_ELEM_W)) dut (
        .IF_clk     (IF_clk),
        .IF_rst     (IF_rst),
        .tick_1ms   (tick_1ms),
        .cw_key_req (cw_key_req),
        .host_ptt   (host_ptt),
        .tx_inhibit (tx_inhibit),
        .ptt_delay  (ptt_delay),
        .hang_time  (hang_time),
        .ptt_out    (ptt_out),
        .cw_key_out (cw_key_out),
        .txen_start (txen_start),
        .txen_end   (txen_end),
        .state_o    (state_o),
        .elem_count (elem_count)
    );

    initial IF_clk = 1'b0;
    always #5 IF_clk = ~IF_clk;

    typedef struct {
        logic       key;
        logic       host;
        logic       inh;
        logic       tick;
        logic [7:0] dly;
        logic [9:0] hng;
        logic [6:0] exp;   // {state[2:0], ptt, key, start, end}
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, req);
        end
    endtask

    task automatic add(input int k, input int h, input int i, input int t,
                       input int d, input int hg, input int st,
                       input int p, input int ko, input int s, input int e);
        vec_t v;
        v.key  = k[0];
        v.host = h[0];
        v.inh  = i[0];
        v.tick = t[0];
        v.dly  = 8'(d);
        v.hng  = 10'(hg);
        v.exp  = {3'(st), p[0], ko[0], s[0], e[0]};
        tbl.push_back(v);
    endtask

    // Drive inputs, take one rising edge, settle just after it.
    task automatic step(input logic k, input logic h, input logic i, input logic t);
        cw_key_req = k;
        host_ptt   = h;
        tx_inhibit = i;
        tick_1ms   = t;
        @(posedge IF_clk);
        #1;
    endtask

    task automatic do_reset();
        IF_rst = 1'b1;
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        IF_rst = 1'b0;
    endtask

    function automatic logic [6:0] obs();
        return {state_o, ptt_out, cw_key_out, txen_start, txen_end};
    endfunction

    initial begin
        int rise_p, fall_p, pfall_p, n_start, n_end;
        logic prev_k, prev_p;

        IF_rst = 1'b1;
        tick_1ms = 1'b0; cw_key_req = 1'b0; host_ptt = 1'b0; tx_inhibit = 1'b0;
        ptt_delay = 8'd2; hang_time = 10'd2;
        #12;
        chk("reset_outputs", 32'(obs()), 32'd0);
        chk("reset_elem", 32'(elem_count), 32'd0);
        do_reset();

        // ---------------- table-driven state machine walk ----------------
        //   key host inh tick dly hng | st ptt key start end
        add(0,0,0,0, 2,2, 0,0,0,0,0);
        add(1,0,0,0, 2,2, 1,1,0,1,0);  // IDLE -> LEAD, PTT rises
        add(1,0,0,1, 2,2, 1,1,0,0,0);  // count 1 of 2
        add(1,0,0,0, 2,2, 1,1,0,0,0);
        add(1,0,0,1, 2,2, 2,1,1,0,0);  // count 2 -> KEYED
        add(1,0,0,1, 2,2, 2,1,1,0,0);
        add(0,0,0,0, 2,2, 3,1,0,0,0);  // key up -> HANG
        add(0,0,0,1, 2,2, 3,1,0,0,0);
        add(0,0,0,1, 2,2, 0,0,0,0,1);  // hang expiry -> IDLE
        add(0,1,0,0, 2,2, 4,1,0,1,0);  // host PTT -> HOST
        add(1,1,0,0, 2,2, 2,1,1,0,0);  // key in HOST -> KEYED, no lead
        add(0,1,0,0, 2,2, 3,1,0,0,0);
        add(0,1,0,1, 2,2, 3,1,0,0,0);
        add(0,1,0,1, 2,2, 4,1,0,0,0);  // hang expiry with host -> HOST
        add(0,0,0,0, 2,2, 0,0,0,0,1);  // host drop -> IDLE
        add(1,0,1,0, 2,2, 0,0,0,0,0);  // inhibit holds IDLE
        add(0,1,1,0, 2,2, 0,0,0,0,0);
        add(1,0,0,0, 2,2, 1,1,0,1,0);
        add(0,0,0,0, 2,2, 3,1,0,0,0);  // aborted element: LEAD -> HANG
        add(0,0,0,1, 2,2, 3,1,0,0,0);
        add(1,0,0,0, 2,2, 2,1,1,0,0);  // re-key from HANG
        add(1,0,1,0, 2,2, 0,0,0,0,1);  // inhibit in KEYED
        add(0,0,0,0, 2,2, 0,0,0,0,0);
        add(1,0,0,0, 5,2, 1,1,0,1,0);
        add(1,0,0,1, 5,2, 1,1,0,0,0);
        add(1,0,0,1, 5,2, 1,1,0,0,0);
        add(1,0,0,1, 5,2, 1,1,0,0,0);  // count now 3
        add(1,0,0,0, 2,2, 1,1,0,0,0);  // delay lowered below count, no tick
        add(1,0,0,1, 2,2, 2,1,1,0,0);  // expires at next tick
        add(0,0,0,0, 2,0, 3,1,0,0,0);
        add(0,0,0,0, 2,0, 0,0,0,0,1);  // hang_time 0 -> expires first cycle

        for (int r = 0; r < tbl.size(); r++) begin
            ptt_delay = tbl[r].dly;
            hang_time = tbl[r].hng;
            step(tbl[r].key, tbl[r].host, tbl[r].inh, tbl[r].tick);
            chk($sformatf("row%0d", r), 32'(obs()), 32'(tbl[r].exp));
        end

        // ---------------- 5 ms lead, 20 ms key, 10 ms hang ----------------
        do_reset();
        ptt_delay = 8'd5; hang_time = 10'd10;
        rise_p = -1; fall_p = -1; pfall_p = -1; n_start = 0; n_end = 0;
        step(1'b1, 1'b0, 1'b0, 1'b0);
        n_start += int'(txen_start);
        prev_k = cw_key_out; prev_p = ptt_out;
        for (int p = 1; p <= 35; p++) begin
            for (int c = 0; c < 4; c++) begin
                step((p <= 20), 1'b0, 1'b0, (c == 0));
                if (cw_key_out && !prev_k) rise_p = p;
                if (!cw_key_out && prev_k) fall_p = p;
                if (!ptt_out && prev_p) pfall_p = p;
                n_start += int'(txen_start);
                n_end += int'(txen_end);
                prev_k = cw_key_out; prev_p = ptt_out;
            end
        end
        chk("long_key_rise_tick", 32'(rise_p), 32'd5);
        chk("long_key_fall_tick", 32'(fall_p), 32'd21);
        chk("long_ptt_fall_tick", 32'(pfall_p), 32'd31);
        chk("long_start_pulses", 32'(n_start), 32'd1);
        chk("long_end_pulses", 32'(n_end), 32'd1);
        chk("long_elem", 32'(elem_count), 32'd1);

        // ---------------- zero delays, shortest element ----------------
        // Request is held through the single LEAD cycle so it is not aborted.
        do_reset();
        ptt_delay = 8'd0; hang_time = 10'd0;
        n_start = 0; n_end = 0;
        step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("zero_lead", 32'(state_o), 32'd1);
        n_start += int'(txen_start); n_end += int'(txen_end);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("zero_keyed", 32'(state_o), 32'd2);
        n_start += int'(txen_start); n_end += int'(txen_end);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("zero_hang", 32'(state_o), 32'd3);
        n_start += int'(txen_start); n_end += int'(txen_end);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("zero_idle", 32'(state_o), 32'd0);
        n_start += int'(txen_start); n_end += int'(txen_end);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        n_start += int'(txen_start); n_end += int'(txen_end);
        chk("zero_pulses", 32'({n_start[7:0], n_end[7:0]}), 32'h0101);

        // ---------------- re-key 3 ms into a 10 ms hang ----------------
        do_reset();
        ptt_delay = 8'd0; hang_time = 10'd10;
        n_start = 0;
        step(1'b1, 1'b0, 1'b0, 1'b0); n_start += int'(txen_start);
        step(1'b1, 1'b0, 1'b0, 1'b0); n_start += int'(txen_start);
        step(1'b0, 1'b0, 1'b0, 1'b0); n_start += int'(txen_start);
        for (int t = 0; t < 3; t++) begin
            step(1'b0, 1'b0, 1'b0, 1'b1); n_start += int'(txen_start);
            step(1'b0, 1'b0, 1'b0, 1'b0); n_start += int'(txen_start);
        end
        chk("rekey_still_hang", 32'(state_o), 32'd3);
        step(1'b1, 1'b0, 1'b0, 1'b0); n_start += int'(txen_start);
        chk("rekey_keyed", 32'({state_o, cw_key_out}), 32'({3'd2, 1'b1}));
        chk("rekey_start_pulses", 32'(n_start), 32'd1);
        chk("rekey_elem", 32'(elem_count), 32'd2);

        // ---------------- async reset while in LEAD ----------------
        do_reset();
        ptt_delay = 8'd50; hang_time = 10'd2;
        step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("rst_pre_lead", 32'(obs()), 32'({3'd1, 1'b1, 1'b0, 1'b1, 1'b0}));
        #2;
        IF_rst = 1'b1;
        #1;
        chk("rst_async_outputs", 32'(obs()), 32'd0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("rst_held_outputs", 32'(obs()), 32'd0);
        IF_rst = 1'b0;
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("rst_release_idle", 32'(obs()), 32'd0);

        // ---------------- elem_count saturation (3-bit) ----------------
        do_reset();
        ptt_delay = 8'd0; hang_time = 10'd0;
        for (int n = 1; n <= 8; n++) begin
            step(1'b1, 1'b0, 1'b0, 1'b0);
            step(1'b1, 1'b0, 1'b0, 1'b0);
            step(1'b0, 1'b0, 1'b0, 1'b0);
            step(1'b0, 1'b0, 1'b0, 1'b0);
            if (n == 6) chk("sat_elem_6", 32'(elem_count), 32'd6);
            if (n == 7) chk("sat_elem_7", 32'(elem_count), 32'd7);
            if (n == 8) chk("sat_elem_hold", 32'(elem_count), 32'd7);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
